// File: rtl/debit_pin_pkg.sv
//------------------------------------------------------------------------------
// Module  : debit_pin_pkg
// Purpose : Shared types, constants and helpers for the debit PIN controller.
//           Holds the checker state encoding, the digit geometry and the
//           one-hot digit-switch decode/validate functions.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package debit_pin_pkg;

    localparam int DIGIT_W    = 2;
    localparam int NUM_DIGITS = 4;
    localparam int PIN_W      = DIGIT_W * NUM_DIGITS;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_BUG       = 3'd2,
        ST_VERIFY    = 3'd3,
        ST_INCORRECT = 3'd4,
        ST_CORRECT   = 3'd5
    } state_t;

    // Exactly one switch closed is the only legal entry.
    function automatic logic onehot_valid(input logic [3:0] sw);
        logic ok;
        case (sw)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Switch position to digit code; only meaningful when onehot_valid is true.
    function automatic logic [DIGIT_W-1:0] onehot_encode(input logic [3:0] sw);
        logic [DIGIT_W-1:0] code;
        case (sw)
            4'b1000: code = 2'd3;
            4'b0100: code = 2'd2;
            4'b0010: code = 2'd1;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pin_check.sv
//------------------------------------------------------------------------------
// Module  : pin_check
// Purpose : PIN checker. Shifts in accepted digit codes, counts them, and once
//           four are held compares against the stored key. Moore status
//           outputs are registered from the next state so they track `state`.
// Ports   : clk, rst_n (async active-low)
//           press_i     - one-cycle press strobe from the edge detector
//           valid_i     - digit switches are one-hot for this press
//           code_i      - encoded digit code for this press
//           waiting_o / correct_o / incorrect_o / bug_o - status
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pin_check
    import debit_pin_pkg::*;
#(
    parameter logic [PIN_W-1:0] PASSKEY = 8'b0000_1010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               press_i,
    input  logic               valid_i,
    input  logic [DIGIT_W-1:0] code_i,
    output logic               waiting_o,
    output logic               correct_o,
    output logic               incorrect_o,
    output logic               bug_o
);

    // Names of these three registers are relied upon by hierarchical probes.
    state_t           state;
    logic [PIN_W-1:0] password;
    logic [2:0]       dig_count;

    state_t           state_d;
    logic [PIN_W-1:0] password_d;
    logic [2:0]       dig_count_d;

    always_comb begin
        state_d     = state;
        password_d  = password;
        dig_count_d = dig_count;
        case (state)
            ST_IDLE, ST_COLLECT, ST_CORRECT, ST_INCORRECT: begin
                if (press_i) begin
                    if (!valid_i) begin
                        state_d = ST_BUG;
                    end else begin
                        password_d = {password[PIN_W-DIGIT_W-1:0], code_i};
                        // Only COLLECT continues an entry; the others start a new one.
                        if (state == ST_COLLECT) begin
                            dig_count_d = dig_count + 3'd1;
                            state_d     = (dig_count + 3'd1 == 3'(NUM_DIGITS))
                                          ? ST_VERIFY : ST_COLLECT;
                        end else begin
                            dig_count_d = 3'd1;
                            state_d     = ST_COLLECT;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                // Valid presses are ignored here, illegal ones still trap.
                if (press_i && !valid_i)
                    state_d = ST_BUG;
                else
                    state_d = (password == PASSKEY) ? ST_CORRECT : ST_INCORRECT;
            end
            ST_BUG:  state_d = ST_BUG;
            default: state_d = ST_BUG;   // encodings 6 and 7
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            password    <= '0;
            dig_count   <= 3'd0;
            waiting_o   <= 1'b1;
            correct_o   <= 1'b0;
            incorrect_o <= 1'b0;
            bug_o       <= 1'b0;
        end else begin
            state       <= state_d;
            password    <= password_d;
            dig_count   <= dig_count_d;
            waiting_o   <= (state_d == ST_IDLE) || (state_d == ST_COLLECT);
            correct_o   <= (state_d == ST_CORRECT);
            incorrect_o <= (state_d == ST_INCORRECT);
            bug_o       <= (state_d == ST_BUG);
        end
    end

endmodule

`default_nettype wire

// File: rtl/debit_pin.sv
//------------------------------------------------------------------------------
// Module  : debit_pin
// Purpose : Four-digit debit PIN entry controller. Detects rising edges of
//           `submit`, validates/encodes the one-hot digit switches and hands
//           each press to the pin_check instance.
// Ports   : clk, reset (async active-low), digit_switches[3:0], submit
//           waiting, correct, incorrect, bug
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module debit_pin
    import debit_pin_pkg::*;
#(
    parameter logic [7:0] passkey = 8'b0000_1010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_switches,
    input  logic       submit,
    output logic       waiting,
    output logic       correct,
    output logic       incorrect,
    output logic       bug
);

    logic               submit_q;
    logic               w_press;
    logic               w_valid;
    logic [DIGIT_W-1:0] w_code;

    // Previous sample of submit; a held button therefore yields one press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) submit_q <= 1'b0;
        else        submit_q <= submit;
    end

    assign w_press = submit & ~submit_q;
    assign w_valid = onehot_valid(digit_switches);
    assign w_code  = onehot_encode(digit_switches);

    pin_check #(
        .PASSKEY (passkey)
    ) pinchk (
        .clk         (clk),
        .rst_n       (reset),
        .press_i     (w_press),
        .valid_i     (w_valid),
        .code_i      (w_code),
        .waiting_o   (waiting),
        .correct_o   (correct),
        .incorrect_o (incorrect),
        .bug_o       (bug)
    );

endmodule

`default_nettype wire

// File: tb/tb_debit_pin.sv
//------------------------------------------------------------------------------
// Module  : tb_debit_pin
// Purpose : Directed self-checking bench for debit_pin.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_debit_pin;

    logic       clk;
    logic       reset;
    logic [3:0] digit_switches;
    logic       submit;
    logic       waiting, correct, incorrect, bug;

    int n_tests;
    int n_fail;

    localparam logic [7:0] KEY = 8'b0000_1010;

    debit_pin #(.passkey(KEY)) dut (
        .clk            (clk),
        .reset          (reset),
        .digit_switches (digit_switches),
        .submit         (submit),
        .waiting        (waiting),
        .correct        (correct),
        .incorrect      (incorrect),
        .bug            (bug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clean press: submit high for one sampling edge, then low for one.
    // Returns at the negedge after the capture edge.
    task automatic press(input logic [3:0] sw);
        @(negedge clk);
        digit_switches = sw;
        submit         = 1'b1;
        @(negedge clk);
        submit         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        submit = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({waiting, correct, incorrect, bug} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 1000", {waiting, correct, incorrect, bug});
        end
        n_tests++;
        if (dut.pinchk.state !== 3'd0 || dut.pinchk.password !== 8'h00 || dut.pinchk.dig_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_regs: state=%0d pw=%h cnt=%0d want 0 00 0",
                     dut.pinchk.state, dut.pinchk.password, dut.pinchk.dig_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_correct();
        do_reset();
        press(4'b0001);
        press(4'b0001);
        press(4'b0100);
        n_tests++;
        if (dut.pinchk.state !== 3'd1 || waiting !== 1'b1 || dut.pinchk.dig_count !== 3'd3) begin
            n_fail++;
            $display("FAIL correct_collect: state=%0d waiting=%b cnt=%0d want 1 1 3",
                     dut.pinchk.state, waiting, dut.pinchk.dig_count);
        end
        press(4'b0100);
        n_tests++;
        if (dut.pinchk.state !== 3'd3 || dut.pinchk.password !== 8'b0000_1010 ||
            {waiting, correct, incorrect, bug} !== 4'b0000) begin
            n_fail++;
            $display("FAIL correct_verify: state=%0d pw=%b outs=%b want 3 00001010 0000",
                     dut.pinchk.state, dut.pinchk.password, {waiting, correct, incorrect, bug});
        end
        @(negedge clk);
        n_tests++;
        if (dut.pinchk.state !== 3'd5 || {waiting, correct, incorrect, bug} !== 4'b0100) begin
            n_fail++;
            $display("FAIL correct_result: state=%0d outs=%b want 5 0100",
                     dut.pinchk.state, {waiting, correct, incorrect, bug});
        end
    endtask

    task automatic test_incorrect();
        do_reset();
        repeat (4) press(4'b1000);
        n_tests++;
        if (dut.pinchk.state !== 3'd3 || dut.pinchk.password !== 8'hFF) begin
            n_fail++;
            $display("FAIL incorrect_verify: state=%0d pw=%h want 3 ff",
                     dut.pinchk.state, dut.pinchk.password);
        end
        @(negedge clk);
        n_tests++;
        if (dut.pinchk.state !== 3'd4 || {waiting, correct, incorrect, bug} !== 4'b0010) begin
            n_fail++;
            $display("FAIL incorrect_result: state=%0d outs=%b want 4 0010",
                     dut.pinchk.state, {waiting, correct, incorrect, bug});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_pw;
        logic [1:0] code;
        logic [1:0] key_codes [4];
        logic       exp_ok;
        key_codes[0] = 2'd0; key_codes[1] = 2'd0; key_codes[2] = 2'd2; key_codes[3] = 2'd2;
        do_reset();
        exp_pw = 8'h00;
        for (int e = 0; e < 24; e++) begin
            for (int d = 0; d < 4; d++) begin
                if (e % 3 == 0) code = key_codes[d];
                else            code = 2'($urandom_range(0, 3));
                exp_pw = {exp_pw[5:0], code};
                press(4'b0001 << code);
            end
            n_tests++;
            if (dut.pinchk.password !== exp_pw || dut.pinchk.state !== 3'd3) begin
                n_fail++;
                $display("FAIL b2b_capture[%0d]: pw=%h state=%0d want pw=%h state=3",
                         e, dut.pinchk.password, dut.pinchk.state, exp_pw);
            end
            @(negedge clk);
            exp_ok = (exp_pw == KEY);
            n_tests++;
            if ({waiting, correct, incorrect, bug} !== {1'b0, exp_ok, ~exp_ok, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: outs=%b want %b", e,
                         {waiting, correct, incorrect, bug}, {1'b0, exp_ok, ~exp_ok, 1'b0});
            end
        end
    endtask

    task automatic test_bug();
        do_reset();
        press(4'b0000);
        n_tests++;
        if ({waiting, correct, incorrect, bug} !== 4'b0001 || dut.pinchk.state !== 3'd2 ||
            dut.pinchk.dig_count !== 3'd0 || dut.pinchk.password !== 8'h00) begin
            n_fail++;
            $display("FAIL bug_zero: outs=%b state=%0d cnt=%0d pw=%h want 0001 2 0 00",
                     {waiting, correct, incorrect, bug}, dut.pinchk.state,
                     dut.pinchk.dig_count, dut.pinchk.password);
        end
        press(4'b0010);
        press(4'b1000);
        n_tests++;
        if (bug !== 1'b1 || dut.pinchk.password !== 8'h00 || dut.pinchk.dig_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bug_sticky: bug=%b pw=%h cnt=%0d want 1 00 0",
                     bug, dut.pinchk.password, dut.pinchk.dig_count);
        end
        do_reset();
        n_tests++;
        if ({waiting, correct, incorrect, bug} !== 4'b1000 || dut.pinchk.state !== 3'd0) begin
            n_fail++;
            $display("FAIL bug_reset: outs=%b state=%0d want 1000 0",
                     {waiting, correct, incorrect, bug}, dut.pinchk.state);
        end
        press(4'b0010);
        press(4'b1100);
        n_tests++;
        if (bug !== 1'b1 || dut.pinchk.dig_count !== 3'd1 || dut.pinchk.password !== 8'h01) begin
            n_fail++;
            $display("FAIL bug_multihot: bug=%b cnt=%0d pw=%h want 1 1 01",
                     bug, dut.pinchk.dig_count, dut.pinchk.password);
        end
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk);
        digit_switches = 4'b0010;
        submit         = 1'b1;
        repeat (3) @(negedge clk);
        submit = 1'b0;
        n_tests++;
        if (dut.pinchk.dig_count !== 3'd1 || dut.pinchk.password !== 8'h01) begin
            n_fail++;
            $display("FAIL hold_one_digit: cnt=%0d pw=%h want 1 01",
                     dut.pinchk.dig_count, dut.pinchk.password);
        end
        press(4'b0100);
        press(4'b1000);
        // Fourth digit held high straight through VERIFY and into the result.
        @(negedge clk);
        digit_switches = 4'b0001;
        submit         = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dut.pinchk.state !== 3'd3 || dut.pinchk.dig_count !== 3'd4) begin
            n_fail++;
            $display("FAIL hold_verify: state=%0d cnt=%0d want 3 4",
                     dut.pinchk.state, dut.pinchk.dig_count);
        end
        repeat (2) @(negedge clk);
        submit = 1'b0;
        n_tests++;
        if (dut.pinchk.state !== 3'd4 || dut.pinchk.password !== 8'b01_10_11_00 ||
            dut.pinchk.dig_count !== 3'd4) begin
            n_fail++;
            $display("FAIL hold_no_extra: state=%0d pw=%b cnt=%0d want 4 01101100 4",
                     dut.pinchk.state, dut.pinchk.password, dut.pinchk.dig_count);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b0;
        submit         = 1'b0;
        digit_switches = 4'b0000;
        test_reset();
        test_correct();
        test_incorrect();
        test_back_to_back();
        test_bug();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
